// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - load/store initiator between the CPU MEM stage and a word-wide data bus
//
// Purpose: accepts one load or store from the MEM stage and checks its alignment and
//   width. It runs a single req/ready bus cycle with byte enables and lane-replicated
//   write data. Load data is extracted from its lane and extended, then returned with a
//   one-cycle done pulse. The pipeline is stalled while the access is in flight.
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   cpu_mem_read/cpu_mem_write   load/store request, held while cpu_stall is high
//   cpu_addr, cpu_wdata          byte address and store data (value in the low bits)
//   cpu_funct3                   RV32I width/sign code
//   cpu_stall                    combinational pipeline freeze
//   cpu_done, cpu_rdata          completion pulse and extended load data
//   cpu_misalign, cpu_bus_err    completion status qualifiers
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata            registered bus request
//   bus_rdata, bus_ready         responder read word and completion

module lsu_bus_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_funct3,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_misalign,
  output logic        cpu_bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          req_in;
  logic          legal;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  // Request decode: width/sign legality, alignment, lane enables and replicated data.
  always_comb begin
    req_in = cpu_mem_read | cpu_mem_write;
    legal  = 1'b1;
    if (cpu_funct3 == 3'b011 || cpu_funct3[2:1] == 2'b11) legal = 1'b0;
    // Unsigned variants exist only for loads.
    if (cpu_mem_write && cpu_funct3[2]) legal = 1'b0;
    if (cpu_funct3[1:0] == 2'b01 && cpu_addr[0]) legal = 1'b0;
    if (cpu_funct3[1:0] == 2'b10 && cpu_addr[1:0] != 2'b00) legal = 1'b0;

    case (cpu_funct3[1:0])
      2'b00:   begin be_new = 4'b0001 << cpu_addr[1:0]; wdata_new = {4{cpu_wdata[7:0]}};  end
      2'b01:   begin be_new = 4'b0011 << cpu_addr[1:0]; wdata_new = {2{cpu_wdata[15:0]}}; end
      default: begin be_new = 4'b1111;                  wdata_new = cpu_wdata;            end
    endcase
  end

  // Load lane extraction and extension from the captured word.
  always_comb begin
    ld_byte = rdata_q[{off_q, 3'b000} +: 8];
    ld_half = rdata_q[{off_q[1], 4'b0000} +: 16];
    case (f3_q[1:0])
      2'b00:   ld_ext = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (req_in) begin
          if (legal) begin
            state_d     = REQ;
            cnt_d       = '0;
            bus_we_d    = cpu_mem_write;
            bus_addr_d  = {cpu_addr[31:2], 2'b00};
            bus_be_d    = be_new;
            bus_wdata_d = wdata_new;
            f3_d        = cpu_funct3;
            off_d       = cpu_addr[1:0];
            // Cleared so a timed-out load returns zero.
            rdata_d     = '0;
            err_d       = 1'b0;
          end else begin
            state_d = ERR;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_ready) begin
          rdata_d = bus_rdata;
          state_d = DONE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    bus_req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Stall is forced low during reset so a held request cannot freeze the pipe.
  assign cpu_stall    = ~rst & (((state_q == IDLE) & req_in) | (state_q == REQ));
  assign cpu_done     = (state_q == DONE) | (state_q == ERR);
  assign cpu_misalign = (state_q == ERR);
  assign cpu_bus_err  = (state_q == DONE) & err_q;
  assign cpu_rdata    = ((state_q == DONE) && !bus_we_q) ? ld_ext : 32'h0;

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb/tb_lsu_bus_master.sv - self-checking bench for lsu_bus_master

module tb_lsu_bus_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_mem_read, cpu_mem_write;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic        cpu_stall, cpu_done, cpu_misalign, cpu_bus_err;
  logic [31:0] cpu_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ready;

  always #5 clk = ~clk;

  lsu_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_misalign(cpu_misalign), .cpu_bus_err(cpu_bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  // Expected outputs for the current cycle, set by the transaction model.
  logic        e_stall, e_done, e_mis, e_err, e_req, e_we;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_be;

  // Observations used by the directed literal checks.
  int          req_cnt, done_cnt, done_cyc, start_cyc;
  logic [3:0]  l_be;
  logic [31:0] l_baddr, l_bwd, l_rdata;
  logic        l_bwe, l_mis, l_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 >= 6) return 1'b0;
    if (wr && f3 >= 4) return 1'b0;
    if (f3[1:0] == 2'd1 && a % 2 != 0) return 1'b0;
    if (f3[1:0] == 2'd2 && a % 4 != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sh;
    sh = int'(a % 4);
    if (f3[1:0] == 2'd0) return 4'(1 << sh);
    if (f3[1:0] == 2'd1) return 4'(3 << sh);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (f3[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    if (f3[1:0] == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (f3 < 4 && v >= 32'h80) v = v - 32'h100;
    end else if (f3[1:0] == 2'd1) begin
      v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (f3 < 4 && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic exp_idle();
    e_stall = 0; e_done = 0; e_mis = 0; e_err = 0; e_req = 0; e_we = 0;
    e_rdata = 0; e_addr = 0; e_wdata = 0; e_be = 0;
  endtask

  // Single compare process: every cycle the bench enables it, all outputs are checked.
  always @(negedge clk) begin
    cyc++;
    if (bus_req) begin
      req_cnt++;
      l_be = bus_be; l_baddr = bus_addr; l_bwd = bus_wdata; l_bwe = bus_we;
    end
    if (cpu_done) begin
      done_cnt++; done_cyc = cyc;
      l_rdata = cpu_rdata; l_mis = cpu_misalign; l_err = cpu_bus_err;
    end
    if (chk_en) begin
      chk("stall", 32'(cpu_stall), 32'(e_stall));
      chk("done", 32'(cpu_done), 32'(e_done));
      chk("misalign", 32'(cpu_misalign), 32'(e_mis));
      chk("bus_err", 32'(cpu_bus_err), 32'(e_err));
      chk("rdata", cpu_rdata, e_rdata);
      chk("bus_req", 32'(bus_req), 32'(e_req));
      if (e_req) begin
        chk("bus_we", 32'(bus_we), 32'(e_we));
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_be", 32'(bus_be), 32'(e_be));
        if (e_we) chk("bus_wdata", bus_wdata, e_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_mem_read = 0; cpu_mem_write = 0;
    exp_idle();
    for (int i = 0; i < n; i++) begin
      bus_ready = 1'($urandom);
      bus_rdata = $urandom;
      step();
    end
  endtask

  // One access, described by its operands and the responder's wait count (-1 = never ready).
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                     input int waits);
    logic ok, to;
    int nreq;
    ok = m_legal(wr, f3, a);
    req_cnt = 0;
    start_cyc = cyc + 1;
    cpu_mem_read = rd; cpu_mem_write = wr; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd;
    bus_ready = 1'($urandom); bus_rdata = $urandom;
    exp_idle();
    e_stall = 1;
    step();
    if (!ok) begin
      exp_idle();
      e_done = 1; e_mis = 1;
      bus_ready = 1'($urandom);
      step();
    end else begin
      to = (waits < 0) || (waits >= TO);
      nreq = to ? TO : waits + 1;
      for (int i = 0; i < nreq; i++) begin
        exp_idle();
        e_req = 1; e_stall = 1; e_we = wr;
        e_addr = a & 32'hFFFF_FFFC;
        e_be = m_be(f3, a);
        e_wdata = m_wdata(f3, wd);
        // The CPU side may change freely while the bus cycle runs.
        cpu_addr = $urandom; cpu_wdata = $urandom; cpu_funct3 = 3'($urandom);
        bus_ready = (i == waits);
        bus_rdata = (i == waits) ? rw : $urandom;
        step();
      end
      exp_idle();
      e_done = 1; e_err = to;
      e_rdata = (wr || to) ? 32'h0 : m_load(f3, a, rw);
      bus_ready = 1'($urandom);
      step();
    end
    cpu_mem_read = 0; cpu_mem_write = 0;
    exp_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    logic rd, wr;
    rst = 1; cpu_mem_read = 0; cpu_mem_write = 1; cpu_addr = 0; cpu_wdata = 0; cpu_funct3 = 0;
    bus_rdata = 0; bus_ready = 0;
    req_cnt = 0; done_cnt = 0; done_cyc = 0; start_cyc = 0;
    exp_idle();
    #3;
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_done", 32'(cpu_done), 0);
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_be", 32'(bus_be), 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_flags", {30'd0, cpu_misalign, cpu_bus_err}, 0);
    step();
    rst = 0;
    cpu_mem_write = 0;
    chk_en = 1;
    idle(2);

    chk("model_lb", m_load(3'b000, 32'h1003, 32'h80FF1234), 32'hFFFFFF80);
    chk("model_lhu", m_load(3'b101, 32'h1002, 32'h80FF1234), 32'h000080FF);
    chk("model_sb_wd", m_wdata(3'b000, 32'h123456A5), 32'hA5A5A5A5);

    txn(1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 0);
    chk("lb_be", 32'(l_be), 32'b1000);
    chk("lb_rdata", l_rdata, 32'hFFFFFF80);
    chk("lb_latency", done_cyc - start_cyc + 1, 3);
    txn(1, 0, 3'b100, 32'h1003, 32'h0, 32'h80FF1234, 0);
    chk("lbu_rdata", l_rdata, 32'h00000080);

    txn(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1);
    chk("sh_addr", l_baddr, 32'h100);
    chk("sh_be", 32'(l_be), 32'b1100);
    chk("sh_wdata", l_bwd, 32'hABCDABCD);
    chk("sh_we", 32'(l_bwe), 1);

    txn(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    chk("misalign_req_cnt", req_cnt, 0);
    chk("misalign_flag", 32'(l_mis), 1);
    chk("misalign_latency", done_cyc - start_cyc + 1, 2);

    txn(1, 0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 3);
    chk("wait3_req_cnt", req_cnt, 4);
    chk("wait3_latency", done_cyc - start_cyc + 1, 6);
    chk("wait3_rdata", l_rdata, 32'hCAFEF00D);

    txn(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, -1);
    chk("timeout_req_cnt", req_cnt, 4);
    chk("timeout_err", 32'(l_err), 1);
    chk("timeout_rdata", l_rdata, 0);

    // Reset in the second REQ cycle abandons the access silently.
    d0 = done_cnt;
    cpu_mem_read = 0; cpu_mem_write = 1; cpu_funct3 = 3'b010;
    cpu_addr = 32'h400; cpu_wdata = 32'h11223344; bus_ready = 0;
    exp_idle(); e_stall = 1;
    step();
    e_stall = 1; e_req = 1; e_we = 1; e_addr = 32'h400; e_be = 4'hF; e_wdata = 32'h11223344;
    step();
    chk_en = 0;
    chk("rst_mid_req_before", 32'(bus_req), 1);
    #1 rst = 1;
    #1;
    chk("rst_mid_req", 32'(bus_req), 0);
    chk("rst_mid_stall", 32'(cpu_stall), 0);
    chk("rst_mid_done", 32'(cpu_done), 0);
    step();
    rst = 0;
    chk_en = 1;
    idle(3);
    chk("rst_mid_no_done", done_cnt, d0);
    txn(0, 1, 3'b010, 32'h404, 32'h55667788, 32'h0, 1);
    chk("after_rst_sw_wdata", l_bwd, 32'h55667788);
    chk("after_rst_sw_done", done_cnt, d0 + 1);

    for (int n = 0; n < 250; n++) begin
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      txn(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 6)) - 1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
